// File: rtl/ir_pkg.sv
// Shared defaults and latency-table helper for the sequenced instruction register.
package ir_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefOpcW  = 3;
  localparam int unsigned DefCntW  = 3;

  // Extra execution cycles per opcode, listed opcode 7 down to opcode 0.
  localparam logic [(2**DefOpcW)*DefCntW-1:0] DefLatTable =
    {3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 3'd3, 3'd0};

  localparam int unsigned DefHaltOpc = 0;

  // Wide enough for any table up to 32 opcodes of 8-bit counts.
  localparam int unsigned LutMaxW = 256;

  // Returns the table shifted so the selected count sits in the LSBs; caller truncates.
  function automatic logic [LutMaxW-1:0] lat_lookup(input logic [LutMaxW-1:0] tbl,
                                                    input int unsigned       op,
                                                    input int unsigned       cnt_w);
    return tbl >> (op * cnt_w);
  endfunction

endpackage

// File: rtl/ir_cycle_counter.sv
// Loadable down-counter with flush, zero detect and a registered done pulse on window end.
module ir_cycle_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (flush) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d  = load_val;
      // A zero-latency instruction finishes in the same cycle it issues.
      done_d = (load_val == '0);
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);
  assign done  = done_q;

endmodule

// File: rtl/instr_seq_reg.sv
// Instruction register with per-opcode execution window and issue/done strobes.
// Optional halt support is enabled by defining IR_HALT_EN.
module instr_seq_reg
  import ir_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned OPC_W  = DefOpcW,
  parameter int unsigned CNT_W  = DefCntW,
  parameter logic [(2**OPC_W)*CNT_W-1:0] LAT_TABLE = DefLatTable,
  parameter logic [OPC_W-1:0] HALT_OPC = OPC_W'(DefHaltOpc),
  localparam int unsigned ADDR_W = DATA_W - OPC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr_data,
  output logic              instr_ready,
  input  logic              flush,
  input  logic              resume,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic [CNT_W-1:0]  cycles_left,
  output logic              issue,
  output logic              done,
  output logic              halted
);

  logic [OPC_W-1:0]  opc_in;
  logic [ADDR_W-1:0] addr_in;
  logic [CNT_W-1:0]  lat_sel;
  logic              accept;
  logic              cnt_zero;
  logic [OPC_W-1:0]  opcode_q;
  logic [ADDR_W-1:0] address_q;
  logic              issue_q;

  assign opc_in      = instr_data[DATA_W-1 -: OPC_W];
  assign addr_in     = instr_data[ADDR_W-1:0];
  assign lat_sel     = CNT_W'(lat_lookup(LutMaxW'(LAT_TABLE), 32'(opc_in), CNT_W));
  assign instr_ready = cnt_zero && !flush && !halted;
  assign accept      = instr_valid && instr_ready;

  ir_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (lat_sel),
    .flush    (flush),
    .count    (cycles_left),
    .zero     (cnt_zero),
    .done     (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= '0;
      address_q <= '0;
      issue_q   <= 1'b0;
    end else begin
      issue_q <= accept;
      if (accept) begin
        opcode_q  <= opc_in;
        address_q <= addr_in;
      end
    end
  end

  assign opcode  = opcode_q;
  assign address = address_q;
  assign issue   = issue_q;
  assign busy    = !cnt_zero;

`ifdef IR_HALT_EN
  logic halted_q, halted_d;

  always_comb begin
    halted_d = halted_q;
    if (halted_q && resume) begin
      halted_d = 1'b0;
    end else if (accept && (opc_in == HALT_OPC)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  logic unused_cfg;

  assign unused_cfg = resume ^ (^HALT_OPC);
  assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_instr_seq_reg.sv
// Table-driven bench for instr_seq_reg with an issue-order scoreboard of accepted words.
module tb_instr_seq_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [7:0] instr_data = 8'h00;
  logic       flush = 1'b0;
  logic       resume = 1'b0;
  logic       instr_ready;
  logic [2:0] opcode;
  logic [4:0] address;
  logic       busy;
  logic [2:0] cycles_left;
  logic       issue;
  logic       done;
  logic       halted;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb[$];

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       flush;
    logic       ready;
    logic [2:0] op;
    logic [4:0] addr;
    logic [2:0] cyc;
    logic       iss;
    logic       dn;
  } vec_t;

  vec_t vecs[$];

  instr_seq_reg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_ready (instr_ready),
    .flush       (flush),
    .resume      (resume),
    .opcode      (opcode),
    .address     (address),
    .busy        (busy),
    .cycles_left (cycles_left),
    .issue       (issue),
    .done        (done),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic f,
                              input logic rdy, input logic [2:0] op, input logic [4:0] addr,
                              input logic [2:0] cyc, input logic iss, input logic dn);
    vec_t r;
    r.valid = v;  r.data = d;   r.flush = f;  r.ready = rdy;
    r.op    = op; r.addr = addr; r.cyc = cyc; r.iss = iss; r.dn = dn;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check ready mid-cycle, and retire/queue scoreboard entries.
  task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r,
                      input logic exp_rdy, input string tag);
    logic [7:0] w;
    @(posedge clk);
    #1;
    instr_valid = v;
    instr_data  = d;
    flush       = f;
    resume      = r;
    @(negedge clk);
    chk({tag, " ready"}, 32'(instr_ready), 32'(exp_rdy));
    if (issue === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s spurious issue: got issue=1 expected issue=0", tag);
      end else begin
        w = sb.pop_front();
        chk({tag, " sb opcode"}, 32'(opcode), 32'(w[7:5]));
        chk({tag, " sb address"}, 32'(address), 32'(w[4:0]));
      end
    end
    if (v && exp_rdy) sb.push_back(d);
  endtask

  initial begin
    logic [2:0] hold_op;
    logic [4:0] hold_addr;

    // Main sequence: opcode 2 window, opcode 6 flushed, flush+valid blocked.
    vecs.push_back(mk(1, 8'h47, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 2, 7, 5, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 2, 7, 4, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 2, 7, 3, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 2, 7, 2, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 2, 7, 1, 0, 0));
    vecs.push_back(mk(1, 8'hC3, 0, 1, 2, 7, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 6, 3, 4, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 6, 3, 3, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 6, 3, 2, 0, 0));
    vecs.push_back(mk(1, 8'h25, 1, 0, 6, 3, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 6, 3, 0, 0, 0));
`ifndef IR_HALT_EN
    // Back-to-back zero-latency words.
    vecs.push_back(mk(1, 8'h01, 0, 1, 6, 3, 0, 0, 0));
    vecs.push_back(mk(1, 8'h02, 0, 1, 0, 1, 0, 1, 1));
    vecs.push_back(mk(1, 8'h03, 0, 1, 0, 2, 0, 1, 1));
    vecs.push_back(mk(1, 8'h1F, 0, 1, 0, 3, 0, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 31, 0, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 31, 0, 0, 0));
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst opcode", 32'(opcode), 0);
    chk("rst address", 32'(address), 0);
    chk("rst cycles", 32'(cycles_left), 0);
    chk("rst issue", 32'(issue), 0);
    chk("rst done", 32'(done), 0);
    chk("rst halted", 32'(halted), 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vecs[i].valid, vecs[i].data, vecs[i].flush, 1'b0, vecs[i].ready, tag);
      chk({tag, " opcode"}, 32'(opcode), 32'(vecs[i].op));
      chk({tag, " address"}, 32'(address), 32'(vecs[i].addr));
      chk({tag, " cycles"}, 32'(cycles_left), 32'(vecs[i].cyc));
      chk({tag, " busy"}, 32'(busy), 32'(vecs[i].cyc != 3'd0));
      chk({tag, " issue"}, 32'(issue), 32'(vecs[i].iss));
      chk({tag, " done"}, 32'(done), 32'(vecs[i].dn));
    end

    // Idle: fields hold, no pulses, counter stays at 0.
    hold_op   = vecs[vecs.size()-1].op;
    hold_addr = vecs[vecs.size()-1].addr;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, "idle");
      chk("idle opcode", 32'(opcode), 32'(hold_op));
      chk("idle address", 32'(address), 32'(hold_addr));
      chk("idle pulses", 32'({issue, done}), 0);
      chk("idle cycles", 32'(cycles_left), 0);
    end

    // Reset mid-window clears everything asynchronously, no done afterwards.
    step(1'b1, 8'h2A, 1'b0, 1'b0, 1'b1, "rstwin acc");
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "rstwin run");
    chk("rstwin cycles pre", 32'(cycles_left), 3);
    #1 rst_n = 1'b0;
    #1;
    chk("rstwin opcode", 32'(opcode), 0);
    chk("rstwin address", 32'(address), 0);
    chk("rstwin cycles", 32'(cycles_left), 0);
    chk("rstwin pulses", 32'({issue, done, halted, busy}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "post rst");
      chk("post rst done", 32'(done), 0);
      chk("post rst cycles", 32'(cycles_left), 0);
    end

`ifdef IR_HALT_EN
    // Halt holds off fetch until resume.
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "halt acc");
    step(1'b1, 8'h45, 1'b0, 1'b0, 1'b0, "halt set");
    chk("halt halted", 32'(halted), 1);
    chk("halt issue/done", 32'({issue, done}), 32'(2'b11));
    for (int i = 0; i < 19; i++) begin
      step(1'b1, 8'h45, 1'b0, 1'b0, 1'b0, "halt hold");
      chk("halt hold halted", 32'(halted), 1);
    end
    step(1'b1, 8'h45, 1'b1, 1'b0, 1'b0, "halt flush");
    step(1'b1, 8'h45, 1'b0, 1'b1, 1'b0, "halt resume");
    chk("halt resume halted", 32'(halted), 1);
    step(1'b1, 8'h45, 1'b0, 1'b0, 1'b1, "halt clear");
    chk("halt clear halted", 32'(halted), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "halt next");
    chk("halt next issue", 32'(issue), 1);
`endif

    chk("sb drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
